// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage and the decode-stage control block.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble load beats hold, hold beats capture.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic [31:0]      fetch_instr,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic [WIDTH-1:0] fetch_pc_plus4,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC + WIDTH'(4);
      valid    <= 1'b0;
    end else if (bubble) begin
      // PC fields keep their old value; only the instruction is squashed.
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      instr    <= fetch_instr;
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and decode field slices.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  output logic [WIDTH-1:0] instr_addr_o,
  input  logic [31:0]      instr_i,
  output logic [31:0]      instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             valid_o,
  output logic [6:0]       op_o,
  output logic [2:0]       funct3_o,
  output logic             funct7bit_o,
  output logic             misalign_o,
  output logic [31:0]      fetch_count_o
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             bubble, capture;
  logic             misalign_q;
  logic [31:0]      count_q;

  // Bit 0 of the target is dropped like jalr; bit 1 only feeds the misalign flag.
  logic unused_target_bit0;
  assign unused_target_bit0 = redirect_target_i[0];

  assign pc_inc = pc_q + WIDTH'(4);
  assign bubble = redirect_i | flush_i;

  always_comb begin
    // NOTE: defaults first so no branch of the case leaves a variable unassigned
    // and infers a latch.
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        capture = !bubble && !stall_i;
      end
      RUN: capture = !bubble && !stall_i;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_inc;
    if (redirect_i)   pc_d = {redirect_target_i[WIDTH-1:2], 2'b00};
    else if (stall_i) pc_d = pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_i && redirect_target_i[1]) misalign_q <= 1'b1;
      if (capture) count_q <= count_q + 32'd1;
    end
  end

  if_id_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .clk            (clk_i),
    .rst            (rst_i),
    .hold           (stall_i),
    .bubble         (bubble),
    .fetch_instr    (instr_i),
    .fetch_pc       (pc_q),
    .fetch_pc_plus4 (pc_inc),
    .instr          (instr_o),
    .pc             (pc_o),
    .pc_plus4       (pc_plus4_o),
    .valid          (valid_o)
  );

  assign instr_addr_o  = pc_q;
  assign op_o          = instr_o[6:0];
  assign funct3_o      = instr_o[14:12];
  assign funct7bit_o   = instr_o[30];
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected IF/ID state, a monitor compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instr_addr, instr_in, instr, pc, pc_plus4, fetch_count;
  logic        valid, funct7bit, misalign;
  logic [6:0]  op;
  logic [2:0]  funct3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] addr, instr, pc, pc4, cnt;
    logic        valid, mis;
  } exp_t;

  exp_t sb[$];
  int   step_id = 0;

  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, a recognisable pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return {a[21:0], 3'b101, 7'h33};
    endcase
  endfunction

  assign instr_in = mem_word(instr_addr);

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .redirect_i        (redirect),
    .redirect_target_i (target),
    .instr_addr_o      (instr_addr),
    .instr_i           (instr_in),
    .instr_o           (instr),
    .pc_o              (pc),
    .pc_plus4_o        (pc_plus4),
    .valid_o           (valid),
    .op_o              (op),
    .funct3_o          (funct3),
    .funct7bit_o       (funct7bit),
    .misalign_o        (misalign),
    .fetch_count_o     (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at a falling edge; applies inputs for the next rising edge and
  // records what IF/ID must look like after it.
  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic e_valid,
                      input logic [31:0] e_cnt, input logic e_mis);
    exp_t e;
    stall = s; flush = f; redirect = r; target = t;
    step_id++;
    e.id = step_id; e.addr = e_addr; e.instr = e_instr; e.pc = e_pc;
    e.pc4 = e_pc + 32'd4; e.valid = e_valid; e.cnt = e_cnt; e.mis = e_mis;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("s%0d instr_addr", e.id), instr_addr, e.addr);
        check($sformatf("s%0d instr", e.id), instr, e.instr);
        check($sformatf("s%0d pc", e.id), pc, e.pc);
        check($sformatf("s%0d pc_plus4", e.id), pc_plus4, e.pc4);
        check($sformatf("s%0d valid", e.id), {31'b0, valid}, {31'b0, e.valid});
        check($sformatf("s%0d count", e.id), fetch_count, e.cnt);
        check($sformatf("s%0d misalign", e.id), {31'b0, misalign}, {31'b0, e.mis});
        check($sformatf("s%0d op", e.id), {25'b0, op}, {25'b0, e.instr[6:0]});
        check($sformatf("s%0d funct3", e.id), {29'b0, funct3}, {29'b0, e.instr[14:12]});
        check($sformatf("s%0d funct7bit", e.id), {31'b0, funct7bit}, {31'b0, e.instr[30]});
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, " instr_addr"}, instr_addr, 32'h0);
    check({tag, " instr"}, instr, NOP);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " pc_plus4"}, pc_plus4, 32'h4);
    check({tag, " valid"}, {31'b0, valid}, 32'h0);
    check({tag, " misalign"}, {31'b0, misalign}, 32'h0);
    check({tag, " count"}, fetch_count, 32'h0);
    check({tag, " op"}, {25'b0, op}, 32'h13);
  endtask

  initial begin : stimulus
    #1 rst = 1'b1;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   s  f  r  target        addr          instr                      pc            v  cnt    mis
    // free run
    step(0, 0, 0, 32'h0,        32'h4,        32'h0050_0093,             32'h0,        1, 32'd1, 0);
    step(0, 0, 0, 32'h0,        32'h8,        32'h00A0_0113,             32'h4,        1, 32'd2, 0);
    // stall three cycles at pc_q = 8
    step(1, 0, 0, 32'h0,        32'h8,        32'h00A0_0113,             32'h4,        1, 32'd2, 0);
    step(1, 0, 0, 32'h0,        32'h8,        32'h00A0_0113,             32'h4,        1, 32'd2, 0);
    step(1, 0, 0, 32'h0,        32'h8,        32'h00A0_0113,             32'h4,        1, 32'd2, 0);
    step(0, 0, 0, 32'h0,        32'hC,        mem_word(32'h8),           32'h8,        1, 32'd3, 0);
    // redirect to 0x40 at pc_q = 12
    step(0, 0, 1, 32'h40,       32'h40,       NOP,                       32'h8,        0, 32'd3, 0);
    step(0, 0, 0, 32'h0,        32'h44,       mem_word(32'h40),          32'h40,       1, 32'd4, 0);
    // flush alone, then flush with stall
    step(0, 1, 0, 32'h0,        32'h48,       NOP,                       32'h40,       0, 32'd4, 0);
    step(0, 0, 0, 32'h0,        32'h4C,       mem_word(32'h48),          32'h48,       1, 32'd5, 0);
    step(1, 1, 0, 32'h0,        32'h4C,       NOP,                       32'h48,       0, 32'd5, 0);
    step(0, 0, 0, 32'h0,        32'h50,       mem_word(32'h4C),          32'h4C,       1, 32'd6, 0);
    // redirect with stall: redirect wins
    step(1, 0, 1, 32'h80,       32'h80,       NOP,                       32'h4C,       0, 32'd6, 0);
    step(0, 0, 0, 32'h0,        32'h84,       mem_word(32'h80),          32'h80,       1, 32'd7, 0);
    // misaligned target, then a later aligned-bit1 redirect keeps the flag
    step(0, 0, 1, 32'h102,      32'h100,      NOP,                       32'h80,       0, 32'd7, 1);
    step(0, 0, 0, 32'h0,        32'h104,      mem_word(32'h100),         32'h100,      1, 32'd8, 1);
    step(0, 0, 1, 32'h11,       32'h10,       NOP,                       32'h100,      0, 32'd8, 1);
    step(0, 0, 0, 32'h0,        32'h14,       mem_word(32'h10),          32'h10,       1, 32'd9, 1);
    step(0, 0, 0, 32'h0,        32'h18,       mem_word(32'h14),          32'h14,       1, 32'd10, 1);
    step(0, 0, 0, 32'h0,        32'h1C,       mem_word(32'h18),          32'h18,       1, 32'd11, 1);
    step(0, 0, 0, 32'h0,        32'h20,       mem_word(32'h1C),          32'h1C,       1, 32'd12, 1);

    // reset between edges while pc_q = 0x20: takes effect with no clock edge
    #2 rst = 1'b1;
    #1 check_reset_state("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 32'h0,        32'h4,        32'h0050_0093,             32'h0,        1, 32'd1, 0);
    // PC wraps modulo 2^32; top address also exercises funct7 bit 30
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,                     32'h0,        0, 32'd1, 0);
    step(0, 0, 0, 32'h0,        32'h0,        mem_word(32'hFFFF_FFFC),   32'hFFFF_FFFC, 1, 32'd2, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2 check("scoreboard drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
